// File: rtl/move_permit_pkg.sv
// Shared types and direction codes for the move-permit controller.
package move_permit_pkg;

  localparam int NUM_DIRS = 4;

  localparam logic [1:0] DIR_CODE_UP    = 2'd0;
  localparam logic [1:0] DIR_CODE_DOWN  = 2'd1;
  localparam logic [1:0] DIR_CODE_LEFT  = 2'd2;
  localparam logic [1:0] DIR_CODE_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    UP    = DIR_CODE_UP,
    DOWN  = DIR_CODE_DOWN,
    LEFT  = DIR_CODE_LEFT,
    RIGHT = DIR_CODE_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    QUALIFY   = 2'd1,
    GRANT     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  function automatic dir_t to_dir(input logic [1:0] code);
    return dir_t'(code);
  endfunction

endpackage

// File: rtl/move_permit_ctrl_enable_reducer.sv
// Registered AND-reduction of one direction's per-element enable vector.
module enable_reducer #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] en,
  output logic         all_en
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_en <= 1'b0;
    end else begin
      all_en <= &en;
    end
  end

endmodule

// File: rtl/move_permit_ctrl.sv
// Move-permit controller: qualifies a directional move request against stable enables.
// Optional timeout/reject path is compiled in when MOVE_PERMIT_TIMEOUT_EN is defined.
module move_permit_ctrl
  import move_permit_pkg::*;
#(
  parameter int NUM_REELS      = 4,
  parameter int NUM_SCROLLS    = 6,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REELS*NUM_SCROLLS-1:0] up_en,
  input  logic [NUM_REELS*NUM_SCROLLS-1:0] down_en,
  input  logic [NUM_REELS*NUM_SCROLLS-1:0] left_en,
  input  logic [NUM_REELS*NUM_SCROLLS-1:0] right_en,
  input  logic                            req_valid,
  input  logic [1:0]                      req_dir,
  output logic                            req_ready,
  output logic                            grant,
  output logic [1:0]                      grant_dir,
  input  logic                            move_done,
  output logic                            reject,
  output logic [3:0]                      all_en,
  output logic                            busy
);

  localparam int N     = NUM_REELS * NUM_SCROLLS;
  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_SAT  = CNT_W'(STABLE_CYCLES);

  generate
    if (N < 1 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("move_permit_ctrl: N, STABLE_CYCLES and TIMEOUT_CYCLES must all be >= 1");
    end
  endgenerate

  logic [N-1:0] en_vec [NUM_DIRS];

  assign en_vec[DIR_CODE_UP]    = up_en;
  assign en_vec[DIR_CODE_DOWN]  = down_en;
  assign en_vec[DIR_CODE_LEFT]  = left_en;
  assign en_vec[DIR_CODE_RIGHT] = right_en;

  generate
    for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_reducer
      enable_reducer #(
        .N(N)
      ) u_reducer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_vec[gi]),
        .all_en(all_en[gi])
      );
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  dir_t             grant_dir_reg, grant_dir_next;
  logic             stable_hit;
  logic             stable_done;

  assign stable_hit  = all_en[grant_dir_reg];
  assign stable_done = stable_hit && (cnt_reg >= STABLE_LAST);

`ifdef MOVE_PERMIT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] q_cnt_reg, q_cnt_next;
  logic            reject_reg;
  logic            timeout_fire;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      grant_dir_reg <= UP;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      grant_dir_reg <= grant_dir_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    grant_dir_next = grant_dir_reg;
`ifdef MOVE_PERMIT_TIMEOUT_EN
    q_cnt_next     = q_cnt_reg;
    timeout_fire   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next     = QUALIFY;
          grant_dir_next = to_dir(req_dir);
          cnt_next       = '0;
`ifdef MOVE_PERMIT_TIMEOUT_EN
          q_cnt_next     = '0;
`endif
        end
      end
      QUALIFY: begin
        // A dropped enable always clears, even on the cycle that would have completed.
        if (!stable_hit) begin
          cnt_next = '0;
        end else if (stable_done) begin
          state_next = GRANT;
          cnt_next   = '0;
        end else if (cnt_reg != STABLE_SAT) begin
          cnt_next = cnt_reg + 1'b1;
        end
`ifdef MOVE_PERMIT_TIMEOUT_EN
        if (q_cnt_reg != TO_SAT) begin
          q_cnt_next = q_cnt_reg + 1'b1;
        end
        // Completion wins over a coinciding timeout.
        if (!stable_done && (q_cnt_reg >= TO_LAST)) begin
          state_next   = IDLE;
          cnt_next     = '0;
          q_cnt_next   = '0;
          timeout_fire = 1'b1;
        end
`endif
      end
      GRANT: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (move_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef MOVE_PERMIT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt_reg  <= '0;
      reject_reg <= 1'b0;
    end else begin
      q_cnt_reg  <= q_cnt_next;
      reject_reg <= timeout_fire;
    end
  end

  assign reject = reject_reg;
`else
  assign reject = 1'b0;
`endif

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign grant     = (state_reg == GRANT);
  assign grant_dir = grant_dir_reg;

endmodule

// File: doc/move_permit_ctrl.md
MOVE_PERMIT_CTRL -- requirements
Module: move_permit_ctrl

Interface
REQ-001 SHALL have parameter NUM_REELS, default 4, the number of reels per scroll row.
REQ-002 SHALL have parameter NUM_SCROLLS, default 6, the number of scroll positions; N = NUM_REELS*NUM_SCROLLS, with N >= 1.
REQ-003 SHALL have parameter STABLE_CYCLES, default 2, the consecutive all-enable cycles required before grant; the minimum value is 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of qualify cycles before reject (used only with the macro).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 up_en, down_en, left_en, right_en  input  N each  per-element enables; bit index = scroll*NUM_REELS + reel.
REQ-008 req_valid  input  1  move request.
REQ-009 req_dir  input  2  requested direction: UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-010 req_ready  output  1  high only in IDLE.
REQ-011 grant  output  1  single-cycle move permission pulse.
REQ-012 grant_dir  output  2  latched direction of the current request.
REQ-013 move_done  input  1  mover reports completion.
REQ-014 reject  output  1  single-cycle timeout pulse.
REQ-015 all_en  output  4  registered AND-reduction per direction, bit = direction code.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 all_en[d] SHALL equal the AND of all N bits of direction d's vector, registered with one cycle of latency.
REQ-018 The FSM SHALL have states IDLE, QUALIFY, GRANT and WAIT_DONE.
REQ-019 IDLE -> QUALIFY on req_valid&&req_ready; req_dir SHALL be latched into grant_dir and the stable counter cleared.
REQ-020 In QUALIFY, each cycle all_en[grant_dir]=1 SHALL increment the counter, and all_en[grant_dir]=0 SHALL clear it to 0.
REQ-021 QUALIFY -> GRANT in the cycle the counter reaches STABLE_CYCLES; grant goes high STABLE_CYCLES+1 cycles after the accept cycle if enables are already stable.
REQ-022 grant SHALL be asserted for exactly one cycle (state GRANT); GRANT -> WAIT_DONE unconditionally.
REQ-023 WAIT_DONE -> IDLE on move_done=1; move_done SHALL be ignored in all other states.
REQ-024 req_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 The stable counter width SHALL be $clog2(STABLE_CYCLES+1) and the counter SHALL saturate and never wrap.
REQ-026 If an enable drops in the same cycle the counter would reach STABLE_CYCLES, there SHALL be no grant and the counter SHALL clear.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, counters=0, grant_dir=0, all_en=0, grant=0, reject=0 and busy=0; req_ready SHALL be 1 after release.
REQ-028 Reset mid-QUALIFY or mid-WAIT_DONE SHALL abandon the request with no grant or reject pulse.

Configuration
REQ-029 With MOVE_PERMIT_TIMEOUT_EN defined, a qualify counter SHALL count QUALIFY cycles; at TIMEOUT_CYCLES without grant, the FSM SHALL pulse reject for one cycle and return to IDLE.
REQ-030 Without MOVE_PERMIT_TIMEOUT_EN, reject SHALL be tied 0, no timeout logic SHALL exist, and QUALIFY SHALL wait indefinitely.
REQ-031 If timeout and stable-count completion coincide, grant SHALL take priority.

Structure
REQ-032 Package move_permit_pkg SHALL hold the dir_t enum (UP, DOWN, LEFT, RIGHT), the state_t enum and the direction code constants.
REQ-033 Sub-module enable_reducer SHALL be instantiated 4 times (one per direction), parameterised by N, with a registered AND-reduction output.

Verification (defaults, macro defined)
REQ-034 All up_en=1, request UP accepted at cycle T -> grant=1 at T+3 only, grant_dir=0, busy until move_done.
REQ-035 down_en bit 13 toggles 0 on alternate cycles while DOWN qualifies -> no grant; bit held high 2 cycles -> grant.
REQ-036 LEFT requested with left_en bit 0 stuck 0 -> reject pulse after 16 QUALIFY cycles, then IDLE and req_ready=1.
REQ-037 rst_n low for 1 cycle during WAIT_DONE -> all outputs reset immediately, no grant or reject, next request accepted.
REQ-038 req_valid with RIGHT held through GRANT/WAIT_DONE -> ignored; move_done during QUALIFY -> ignored.
REQ-039 Rebuilt with NUM_REELS=3, NUM_SCROLLS=5, macro undefined, one bit low -> all_en bit 0 and no reject ever; all 15 bits high -> grant.
